// File: rtl/alzette_ise_pkg.sv
// Shared definitions for the Alzette custom-instruction issuing sequencer.
// Contents:
//   CUSTOM_3 opcode, the ten rotate-combined funct codes, the per-round
//   rotation tables for Alzette (R1/R2) and its inverse (S1/S2), the FSM
//   state encoding, and a helper that maps (operation, rotation) to funct.
package alzette_ise_pkg;

    localparam logic [5:0] CUSTOM_3   = 6'b000011;

    localparam logic [6:0] F_ADDROR31 = 7'h20;
    localparam logic [6:0] F_ADDROR17 = 7'h21;
    localparam logic [6:0] F_ADDROR24 = 7'h22;
    localparam logic [6:0] F_SUBROR31 = 7'h23;
    localparam logic [6:0] F_SUBROR17 = 7'h24;
    localparam logic [6:0] F_SUBROR24 = 7'h25;
    localparam logic [6:0] F_XORROR31 = 7'h26;
    localparam logic [6:0] F_XORROR17 = 7'h27;
    localparam logic [6:0] F_XORROR24 = 7'h28;
    localparam logic [6:0] F_XORROR16 = 7'h29;

    // Rotation tables, element [round]; packed so entry 0 is the rightmost.
    // Encrypt:  R1 = {31,17,0,24}  R2 = {24,17,31,16}
    // Decrypt:  S1 = {24,0,17,31}  S2 = {16,31,17,24}
    localparam logic [3:0][4:0] R1_TBL = {5'd24, 5'd0,  5'd17, 5'd31};
    localparam logic [3:0][4:0] R2_TBL = {5'd16, 5'd31, 5'd17, 5'd24};
    localparam logic [3:0][4:0] S1_TBL = {5'd31, 5'd17, 5'd0,  5'd24};
    localparam logic [3:0][4:0] S2_TBL = {5'd24, 5'd17, 5'd31, 5'd16};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_XOR = 2'd2
    } op_kind_e;

    // Funct code for "rs1 op ROR(rs2, rot)"; 0 means no ISE encoding exists
    // (rotation 0 steps are executed locally).
    function automatic logic [6:0] funct_for(input op_kind_e kind, input logic [4:0] rot);
        logic [6:0] f;
        f = 7'h00;
        case (kind)
            OP_ADD: begin
                case (rot)
                    5'd31:   f = F_ADDROR31;
                    5'd17:   f = F_ADDROR17;
                    5'd24:   f = F_ADDROR24;
                    default: f = 7'h00;
                endcase
            end
            OP_SUB: begin
                case (rot)
                    5'd31:   f = F_SUBROR31;
                    5'd17:   f = F_SUBROR17;
                    5'd24:   f = F_SUBROR24;
                    default: f = 7'h00;
                endcase
            end
            OP_XOR: begin
                case (rot)
                    5'd31:   f = F_XORROR31;
                    5'd17:   f = F_XORROR17;
                    5'd24:   f = F_XORROR24;
                    5'd16:   f = F_XORROR16;
                    default: f = 7'h00;
                endcase
            end
            default: f = 7'h00;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/alzette_seq_rom.sv
// Micro-program ROM for the Alzette sequencer (purely combinational).
// Ports:
//   dec_i       : 0 = Alzette, 1 = inverse Alzette
//   step_i      : micro-step 0..7 (round = step[2:1], phase = step[0])
//   funct_o     : ISE funct code for this step (0 for local steps)
//   tgt_y_o     : 1 = result written to y, 0 = result written to x
//   local_o     : step has rotation 0 and is computed without the ALU
//   local_sub_o : local step subtracts (else adds)
//   xor_c_o     : x is xored with the round constant when this step retires
module alzette_seq_rom
    import alzette_ise_pkg::*;
(
    input  logic       dec_i,
    input  logic [2:0] step_i,
    output logic [6:0] funct_o,
    output logic       tgt_y_o,
    output logic       local_o,
    output logic       local_sub_o,
    output logic       xor_c_o
);

    logic [1:0] round_s;
    logic       phase_s;
    op_kind_e   kind_s;
    logic [4:0] rot_s;

    assign round_s = step_i[2:1];
    assign phase_s = step_i[0];

    // Decode direction/phase into operation, rotation and write-back target.
    always_comb begin
        kind_s  = OP_ADD;
        rot_s   = 5'd0;
        tgt_y_o = 1'b0;
        xor_c_o = 1'b0;
        case ({dec_i, phase_s})
            2'b00: begin            // enc: x = x + ROR(y, R1)
                kind_s  = OP_ADD;
                rot_s   = R1_TBL[round_s];
                tgt_y_o = 1'b0;
                xor_c_o = 1'b0;
            end
            2'b01: begin            // enc: y = y ^ ROR(x, R2), then x ^= c
                kind_s  = OP_XOR;
                rot_s   = R2_TBL[round_s];
                tgt_y_o = 1'b1;
                xor_c_o = 1'b1;
            end
            2'b10: begin            // dec: y = y ^ ROR(x, S2)
                kind_s  = OP_XOR;
                rot_s   = S2_TBL[round_s];
                tgt_y_o = 1'b1;
                xor_c_o = 1'b0;
            end
            2'b11: begin            // dec: x = x - ROR(y, S1), re-apply c except last round
                kind_s  = OP_SUB;
                rot_s   = S1_TBL[round_s];
                tgt_y_o = 1'b0;
                xor_c_o = (round_s != 2'd3);
            end
            default: begin
                kind_s  = OP_ADD;
                rot_s   = 5'd0;
                tgt_y_o = 1'b0;
                xor_c_o = 1'b0;
            end
        endcase
    end

    // Rotation 0 has no ISE encoding; those steps run locally.
    always_comb begin
        local_o     = (rot_s == 5'd0);
        local_sub_o = (kind_s == OP_SUB);
        funct_o     = funct_for(kind_s, rot_s);
    end

endmodule

// File: rtl/alzette_ise_seq.sv
// Issuing end of the Alzette custom-instruction interface.
// Accepts one (x, y, c, direction) job, runs the 4-round Alzette or its
// inverse as 8 micro-steps (7 CUSTOM_3 rotate-combined ALU ops plus one
// local rotation-0 step) and returns (x', y'). Each ALU op is held until
// ise_oval; a per-op timer aborts the job with rsp_err after TMO stall cycles.
// Ports:
//   ise_clk, ise_rst            : clock, asynchronous active-low reset
//   req_val/req_rdy/req_dec     : job handshake and direction (1 = inverse)
//   req_x/req_y/req_c           : job operands and round constant
//   rsp_val/rsp_rdy             : result handshake
//   rsp_x/rsp_y/rsp_err         : result words, timeout abort flag
//   ise_val/ise_fn/ise_imm      : op request to the ISE ALU (CUSTOM_3, funct)
//   ise_in1/ise_in2             : rs1 (register being updated), rs2 (other)
//   ise_oval/ise_out            : ALU result valid and value
module alzette_ise_seq
    import alzette_ise_pkg::*;
#(
    parameter int unsigned TMO = 16
)
(
    input  logic        ise_clk,
    input  logic        ise_rst,
    input  logic        req_val,
    output logic        req_rdy,
    input  logic        req_dec,
    input  logic [31:0] req_x,
    input  logic [31:0] req_y,
    input  logic [31:0] req_c,
    output logic        rsp_val,
    input  logic        rsp_rdy,
    output logic [31:0] rsp_x,
    output logic [31:0] rsp_y,
    output logic        rsp_err,
    output logic        ise_val,
    output logic [5:0]  ise_fn,
    output logic [6:0]  ise_imm,
    output logic [31:0] ise_in1,
    output logic [31:0] ise_in2,
    input  logic        ise_oval,
    input  logic [31:0] ise_out
);

    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    state_e      state_q, state_d;
    logic        dec_q, dec_d;
    logic [2:0]  step_q, step_d;
    logic [31:0] x_q, x_d;
    logic [31:0] y_q, y_d;
    logic [31:0] c_q, c_d;
    logic [7:0]  timer_q, timer_d;

    // Decode of the step currently executing (loaded with the step itself).
    logic        op_tgt_y_q, op_local_q, op_sub_q, op_xorc_q;

    logic        req_rdy_q, req_rdy_d;
    logic        rsp_val_q, rsp_val_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_x_q, rsp_x_d;
    logic [31:0] rsp_y_q, rsp_y_d;
    logic        ise_val_q, ise_val_d;
    logic [5:0]  ise_fn_q, ise_fn_d;
    logic [6:0]  ise_imm_q, ise_imm_d;
    logic [31:0] ise_in1_q, ise_in1_d;
    logic [31:0] ise_in2_q, ise_in2_d;

    logic [6:0]  rom_funct_s;
    logic        rom_tgt_y_s, rom_local_s, rom_local_sub_s, rom_xor_c_s;

    logic        capture_s, stall_s;
    logic [31:0] res_s, cap_x_s, cap_y_s;

    // The ROM looks at the *next* step so op outputs can be registered and
    // appear in the same cycle the step starts.
    alzette_seq_rom u_rom (
        .dec_i       (dec_d),
        .step_i      (step_d),
        .funct_o     (rom_funct_s),
        .tgt_y_o     (rom_tgt_y_s),
        .local_o     (rom_local_s),
        .local_sub_o (rom_local_sub_s),
        .xor_c_o     (rom_xor_c_s)
    );

    assign capture_s = (state_q == ST_RUN) && (op_local_q || (ise_val_q && ise_oval));
    assign stall_s   = (state_q == ST_RUN) && !op_local_q && ise_val_q && !ise_oval;

    // Result of the current step: local add/sub of x and y, or the ALU result.
    always_comb begin
        if (op_local_q) begin
            res_s = op_sub_q ? (x_q - y_q) : (x_q + y_q);
        end else begin
            res_s = ise_out;
        end
    end

    // Register values once the current step retires, including the c fold-in.
    always_comb begin
        cap_y_s = op_tgt_y_q ? res_s : y_q;
        cap_x_s = op_tgt_y_q ? x_q : res_s;
        cap_x_s = op_xorc_q ? (cap_x_s ^ c_q) : cap_x_s;
    end

    // Next-state logic: job accept, step sequencing, timeout and response.
    always_comb begin
        state_d   = state_q;
        dec_d     = dec_q;
        step_d    = step_q;
        x_d       = x_q;
        y_d       = y_q;
        c_d       = c_q;
        timer_d   = timer_q;
        rsp_val_d = rsp_val_q;
        rsp_err_d = rsp_err_q;
        rsp_x_d   = rsp_x_q;
        rsp_y_d   = rsp_y_q;
        case (state_q)
            ST_IDLE: begin
                if (req_val && req_rdy_q) begin
                    state_d = ST_RUN;
                    dec_d   = req_dec;
                    c_d     = req_c;
                    step_d  = 3'd0;
                    timer_d = 8'd0;
                    // The inverse starts by undoing the final c fold-in.
                    x_d     = req_dec ? (req_x ^ req_c) : req_x;
                    y_d     = req_y;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (capture_s) begin
                    x_d     = cap_x_s;
                    y_d     = cap_y_s;
                    timer_d = 8'd0;
                    if (step_q == 3'd7) begin
                        state_d   = ST_RESP;
                        rsp_val_d = 1'b1;
                        rsp_err_d = 1'b0;
                        rsp_x_d   = cap_x_s;
                        rsp_y_d   = cap_y_s;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end else if (stall_s) begin
                    if (timer_q == TMO_LAST) begin
                        // Abort: report whatever the registers hold right now.
                        state_d   = ST_RESP;
                        rsp_val_d = 1'b1;
                        rsp_err_d = 1'b1;
                        rsp_x_d   = x_q;
                        rsp_y_d   = y_q;
                        timer_d   = 8'd0;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end else begin
                    timer_d = timer_q;
                end
            end
            ST_RESP: begin
                if (rsp_rdy) begin
                    state_d   = ST_IDLE;
                    rsp_val_d = 1'b0;
                    rsp_err_d = 1'b0;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                rsp_val_d = 1'b0;
                rsp_err_d = 1'b0;
            end
        endcase
    end

    // Registered interface outputs derived from the next state.
    always_comb begin
        req_rdy_d = (state_d == ST_IDLE);
        ise_val_d = (state_d == ST_RUN) && !rom_local_s;
        ise_fn_d  = ise_val_d ? CUSTOM_3 : 6'd0;
        ise_imm_d = ise_val_d ? rom_funct_s : 7'd0;
        if (ise_val_d) begin
            ise_in1_d = rom_tgt_y_s ? y_d : x_d;
            ise_in2_d = rom_tgt_y_s ? x_d : y_d;
        end else begin
            ise_in1_d = 32'd0;
            ise_in2_d = 32'd0;
        end
    end

    // FSM, datapath and output registers.
    always_ff @(posedge ise_clk or negedge ise_rst) begin
        if (!ise_rst) begin
            state_q    <= ST_IDLE;
            dec_q      <= 1'b0;
            step_q     <= 3'd0;
            x_q        <= 32'd0;
            y_q        <= 32'd0;
            c_q        <= 32'd0;
            timer_q    <= 8'd0;
            op_tgt_y_q <= 1'b0;
            op_local_q <= 1'b0;
            op_sub_q   <= 1'b0;
            op_xorc_q  <= 1'b0;
            req_rdy_q  <= 1'b0;
            rsp_val_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_x_q    <= 32'd0;
            rsp_y_q    <= 32'd0;
            ise_val_q  <= 1'b0;
            ise_fn_q   <= 6'd0;
            ise_imm_q  <= 7'd0;
            ise_in1_q  <= 32'd0;
            ise_in2_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            dec_q      <= dec_d;
            step_q     <= step_d;
            x_q        <= x_d;
            y_q        <= y_d;
            c_q        <= c_d;
            timer_q    <= timer_d;
            op_tgt_y_q <= rom_tgt_y_s;
            op_local_q <= rom_local_s && (state_d == ST_RUN);
            op_sub_q   <= rom_local_sub_s;
            op_xorc_q  <= rom_xor_c_s;
            req_rdy_q  <= req_rdy_d;
            rsp_val_q  <= rsp_val_d;
            rsp_err_q  <= rsp_err_d;
            rsp_x_q    <= rsp_x_d;
            rsp_y_q    <= rsp_y_d;
            ise_val_q  <= ise_val_d;
            ise_fn_q   <= ise_fn_d;
            ise_imm_q  <= ise_imm_d;
            ise_in1_q  <= ise_in1_d;
            ise_in2_q  <= ise_in2_d;
        end
    end

    assign req_rdy = req_rdy_q;
    assign rsp_val = rsp_val_q;
    assign rsp_err = rsp_err_q;
    assign rsp_x   = rsp_x_q;
    assign rsp_y   = rsp_y_q;
    assign ise_val = ise_val_q;
    assign ise_fn  = ise_fn_q;
    assign ise_imm = ise_imm_q;
    assign ise_in1 = ise_in1_q;
    assign ise_in2 = ise_in2_q;

endmodule
